// File: rtl/shift_tx_pkg.sv
// shift_frame_tx shared types: FSM states, frame width, line levels.
// Optional even parity bit is enabled with SHIFT_TX_PARITY_EN.
package shift_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int TX_DATA_W = 16;

  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam logic TX_START_LVL = 1'b0;
  localparam logic TX_STOP_LVL  = 1'b1;

endpackage

// File: rtl/shift_frame_tx_if.sv
// Parallel word handshake into the framed serial transmitter.
// Shared by all builds, with or without SHIFT_TX_PARITY_EN.
interface shift_frame_tx_if
  import shift_tx_pkg::*;
#(
  parameter int DATA_W = TX_DATA_W,
  parameter int DIV_W  = 8
);
  logic [DATA_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              msb_first;
  logic [DIV_W-1:0]  baud_div;

  modport master (
    output word_in,
    output word_valid,
    output msb_first,
    output baud_div,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  msb_first,
    input  baud_div,
    output word_ready
  );
endinterface

// File: rtl/shift_tx_baud.sv
// Loadable bit-period down-counter; bit_end marks the last cycle of a bit.
// Independent of SHIFT_TX_PARITY_EN.
module shift_tx_baud #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/shift_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits, stop bit.
// Define SHIFT_TX_PARITY_EN to insert an even parity bit before stop.
module shift_frame_tx
  import shift_tx_pkg::*;
#(
  parameter int DATA_W = TX_DATA_W,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  shift_frame_tx_if.slave  up,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  tx_state_t         state;
  logic [DATA_W-1:0] word_q;
  logic              msb_q;
  logic [DIV_W-1:0]  div_q;
  logic [4:0]        bit_cnt;

  logic              accept;
  logic              bit_end;
  logic              load;
  logic [DIV_W-1:0]  div_sel;
  logic              last_bit;

  function automatic logic pick(
    input logic [DATA_W-1:0] w,
    input logic [4:0]        idx,
    input logic              msb
  );
    int i;
    i = int'(idx);
    return msb ? w[DATA_W-1-i] : w[i];
  endfunction

  assign up.word_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = up.word_valid && up.word_ready;
  assign done          = (state == STOP) && bit_end;
  assign last_bit      = (bit_cnt == 5'(DATA_W-1));

  // The new divisor is used directly on accept; div_q is not loaded yet.
  assign load    = accept || (busy && bit_end);
  assign div_sel = accept ? up.baud_div : div_q;

  shift_tx_baud #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .div     (div_sel),
    .bit_end (bit_end)
  );

  // tx_out is registered with the state, so it always carries
  // the level of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_out  <= TX_IDLE_LVL;
      word_q  <= '0;
      msb_q   <= 1'b0;
      div_q   <= '0;
      bit_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= START;
            tx_out  <= TX_START_LVL;
            word_q  <= up.word_in;
            msb_q   <= up.msb_first;
            div_q   <= up.baud_div;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx_out  <= pick(word_q, 5'd0, msb_q);
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (last_bit) begin
`ifdef SHIFT_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= ^word_q;
`else
              state  <= STOP;
              tx_out <= TX_STOP_LVL;
`endif
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              tx_out  <= pick(word_q, bit_cnt + 5'd1, msb_q);
            end
          end
        end
`ifdef SHIFT_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            tx_out <= TX_STOP_LVL;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state  <= IDLE;
            tx_out <= TX_IDLE_LVL;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= TX_IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_frame_tx.sv
// Self-checking bench for shift_frame_tx: frame-level queue model
// plus literal frame/length checks. Honours SHIFT_TX_PARITY_EN.
module tb_shift_frame_tx;
  import shift_tx_pkg::*;

`ifdef SHIFT_TX_PARITY_EN
  localparam int NB = 19;
`else
  localparam int NB = 18;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic tx_out, busy, done;

  shift_frame_tx_if #(.DATA_W(16), .DIV_W(8)) bus ();

  shift_frame_tx #(
    .DATA_W (16),
    .DIV_W  (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .up      (bus.slave),
    .tx_out  (tx_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  // Model: one queue entry per line cycle of the frame in flight.
  bit q[$];

  function automatic void push_frame(input logic [15:0] w,
                                     input logic m,
                                     input logic [7:0] d);
    bit seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < 16; i++)
      seq.push_back(m ? w[15-i] : w[i]);
`ifdef SHIFT_TX_PARITY_EN
    seq.push_back(^w);
`endif
    seq.push_back(1'b1);
    foreach (seq[k])
      for (int r = 0; r <= int'(d); r++)
        q.push_back(seq[k]);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit idle;
    if (!reset_n) begin
      q.delete();
    end else begin
      idle = (q.size() == 0);
      if (!idle) void'(q.pop_front());
      if (idle && bus.word_valid)
        push_frame(bus.word_in, bus.msb_first, bus.baud_div);
    end
  end

  // {tx_out, busy, done, word_ready} every cycle
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset_n || q.size() == 0)
      e = 4'b1001;
    else
      e = {q[0], 1'b1, q.size() == 1, 1'b0};
    check("cycle", {tx_out, busy, done, bus.word_ready}, e);
  end

  task automatic send(input  logic [15:0]   w,
                      input  logic          m,
                      input  logic [7:0]    d,
                      input  logic [15:0]   w2,
                      input  logic [7:0]    d2,
                      output logic [NB-1:0] bits,
                      output int            len);
    int n;
    int idx;
    logic s[$];
    n = 0;
    while (!bus.word_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.word_ready, 1);
    bus.word_in    = w;
    bus.msb_first  = m;
    bus.baud_div   = d;
    bus.word_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    bus.word_in    = w2;
    bus.baud_div   = d2;
    bus.msb_first  = ~m;
    n = 0;
    do begin
      @(negedge clk);
      s.push_back(tx_out);
      n++;
    end while (!done && n < 1000);
    check("done_seen", done, 1);
    len = n;
    bits = '0;
    for (int k = 0; k < NB; k++) begin
      idx = k * (int'(d) + 1);
      if (idx < s.size()) bits[NB-1-k] = s[idx];
    end
  endtask

  logic [NB-1:0] bits;
  int len;
  int n;

`ifdef SHIFT_TX_PARITY_EN
  localparam logic [NB-1:0] E_LSB = {1'b0, 16'b1100001110100101, 1'b0, 1'b1};
  localparam logic [NB-1:0] E_MSB = {1'b0, 16'b1010010111000011, 1'b0, 1'b1};
  localparam logic [NB-1:0] E_07  = {1'b0, 16'b1110000000000000, 1'b1, 1'b1};
`else
  localparam logic [NB-1:0] E_LSB = {1'b0, 16'b1100001110100101, 1'b1};
  localparam logic [NB-1:0] E_MSB = {1'b0, 16'b1010010111000011, 1'b1};
  localparam logic [NB-1:0] E_07  = {1'b0, 16'b1110000000000000, 1'b1};
`endif

  initial begin
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    bus.msb_first  = 1'b0;
    bus.baud_div   = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    repeat (20) @(negedge clk);
    check("idle_tx", tx_out, 1);
    check("idle_ready", bus.word_ready, 1);

    send(16'hA5C3, 1'b0, 8'd0, 16'h1234, 8'd5, bits, len);
    check("lsb_bits", bits, E_LSB);
    check("lsb_len", len, NB);
    @(negedge clk);
    check("ready_after_done", bus.word_ready, 1);

    send(16'hA5C3, 1'b1, 8'd3, 16'h0F0F, 8'd1, bits, len);
    check("msb_bits", bits, E_MSB);
    check("msb_len", len, 4 * NB);

    @(negedge clk);
    bus.word_in    = 16'h0001;
    bus.msb_first  = 1'b0;
    bus.baud_div   = 8'd0;
    bus.word_valid = 1'b1;
    @(posedge clk);
    #1 bus.word_in = 16'hFFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    check("b2b_done1", done, 1);
    check("b2b_len1", n, NB);
    @(negedge clk);
    check("gap_idle", {tx_out, bus.word_ready}, 2'b11);
    @(negedge clk);
    check("second_start", tx_out, 0);
    bus.word_valid = 1'b0;
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    check("b2b_len2", n, NB);

    @(negedge clk);
    bus.word_in    = 16'h3C5A;
    bus.msb_first  = 1'b0;
    bus.baud_div   = 8'd0;
    bus.word_valid = 1'b1;
    @(posedge clk);
    #1 bus.word_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    send(16'h0007, 1'b0, 8'd1, 16'hFFFF, 8'd0, bits, len);
    check("post_rst_bits", bits, E_07);
    check("post_rst_len", len, 2 * NB);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
